audio_out_bridge: RTL
=====================

// Module: audio_out_bridge
// PURPOSE
//  Bus-to-stream bridge for the audio output path. The CPU writes 28-bit samples over the simple
//  bus into an internal DEPTH x DATA_SIZE FIFO. The block streams them to the codec serializer
//  with a valid/ready handshake. Pre-fill, underrun and overflow tracking, plus a low-watermark
//  IRQ, let the driver keep the FIFO topped up.
// PARAMETERS
//  DATA_SIZE    28                sample width (<=32)
//  DEPTH        2048              FIFO entries (power of 2)
//  ADDR_WIDTH   $clog2(DEPTH)     FIFO pointer width
//  START_LEVEL  256               FIFO count needed before streaming (re)starts
//  LOW_WATER    512               IRQ asserts while count < LOW_WATER
// PORTS
//  clk          in   1          system clock, 50 MHz
//  rst_n        in   1          asynchronous active-low reset
//  chipselect   in   1          bus select
//  address      in   1          0 = data/status, 1 = control
//  read         in   1          bus read strobe
//  write        in   1          bus write strobe
//  write_data   in   32         bus write data
//  read_data    out  32         registered bus read data
//  sink_valid   out  1          output sample valid
//  sink_data    out  DATA_SIZE  output sample
//  sink_ready   in   1          serializer accepts sample
//  irq          out  1          low-watermark interrupt, level
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; ctrl = 0; sticky flags and counters = 0; state DISABLED.
//  Bus write, addr 0: push write_data[DATA_SIZE-1:0]. If full, the word is dropped and
//   ovf_sticky is set.
//  Bus write, addr 1: control register.
//   [0] enable
//   [1] flush: self-clearing; empties FIFO and output register, state -> FILL if enabled,
//       else DISABLED
//   [2] irq_en
//   [3] clr: self-clearing; clears ovf/udr sticky flags and udr_cnt
//  Bus read (1-cycle latency, read_data valid on the next clk; holds the last value otherwise):
//   addr 0 = status: {udr_cnt[15:0], udr_sticky, ovf_sticky, full, empty, cnt[11:0]}
//            (cnt zero-extended or truncated to 12 bits)
//   addr 1 = {26'b0, state[1:0], 1'b0, irq_en, 1'b0, enable}
//   Reads have no side effects.
//  cnt counts FIFO entries only, 0..DEPTH; the output register is excluded.
//   Push and pop in the same cycle leave cnt unchanged.
//   A push while full is dropped even if a pop occurs in the same cycle.
//   Pointers wrap modulo DEPTH.
//  FSM (state encoding: 0 DISABLED, 1 FILL, 2 STREAM):
//   DISABLED: no pops; sink_valid forced 0 next cycle. enable=1 -> FILL.
//   FILL: no pops. cnt >= START_LEVEL -> STREAM. enable=0 -> DISABLED.
//   STREAM: the output register loads mem[rd_ptr] (pop) when (!sink_valid || sink_ready) && !empty.
//     sink_valid/sink_data hold stable until sink_ready. Sustained throughput is 1 sample/clk.
//     If sink_valid==0 && empty && sink_ready==1: underrun event. udr_sticky=1,
//       udr_cnt += 1 (saturates at 16'hFFFF), state -> FILL.
//     enable=0 -> DISABLED; the in-flight sample in the output register is discarded.
//   flush has priority over enable changes and over a push in the same cycle (that push is dropped).
//   Asynchronous reset mid-stream: immediate return to the reset state; sink_valid drops
//   asynchronously.
//  irq registered: irq <= irq_en && enable && (cnt < LOW_WATER); level-sensitive, no ack needed.
// TESTING
//  1. Reset, enable, push 255 samples -> state FILL, sink_valid=0. Push the 256th -> STREAM
//     within 2 clk; first sink_data equals the first sample written.
//  2. sink_ready held 1, 300 samples queued -> 300 consecutive samples, one per clk, in order;
//     then an underrun: udr_cnt=1, udr_sticky=1, state FILL.
//  3. Push 2049 words with enable=0 -> cnt=2048, full=1, ovf_sticky=1; 2049th word absent on drain.
//  4. sink_ready toggling 1-in-4 with concurrent bus pushes -> cnt exact each cycle; data held
//     stable while sink_ready=0; push and pop in the same cycle leave cnt unchanged.
//  5. irq_en=1, cnt=600, drain to 511 -> irq=1 one clk after cnt<512; push to 512 -> irq=0.
//  6. Flush mid-stream with 1000 queued -> cnt=0, sink_valid=0 next clk, state FILL; rst_n
//     pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_out_bridge.sv
// Bus-to-stream bridge for the audio output path: CPU-written samples are buffered in a
// block-RAM FIFO and streamed to the codec serializer over valid/ready.
module audio_out_bridge #(
  parameter int DATA_SIZE   = 28,
  parameter int DEPTH       = 2048,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int START_LEVEL = 256,
  parameter int LOW_WATER   = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chipselect,
  input  logic                 address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  input  logic                 sink_ready,
  output logic                 irq
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_STREAM   = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [DATA_SIZE-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   enable_reg;
  logic                   irq_en_reg;
  logic                   ovf_sticky_reg;
  logic                   udr_sticky_reg;
  logic [15:0]            udr_cnt_reg;
  logic [11:0]            cnt12;

  logic bus_wr_data;
  logic bus_wr_ctrl;
  logic flush;
  logic clr;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic underrun;

  assign bus_wr_data = chipselect && write && !address;
  assign bus_wr_ctrl = chipselect && write && address;
  assign flush       = bus_wr_ctrl && write_data[1];
  assign clr         = bus_wr_ctrl && write_data[3];
  assign full        = (cnt_reg == CW'(DEPTH));
  assign empty       = (cnt_reg == '0);
  assign push        = bus_wr_data && !full && !flush;

  // The output register refills whenever it is free or being consumed this cycle.
  assign pop      = (state_reg == ST_STREAM) && enable_reg && !flush &&
                    (!sink_valid || sink_ready) && !empty;
  assign underrun = (state_reg == ST_STREAM) && enable_reg && !flush &&
                    !sink_valid && empty && sink_ready;

  generate
    if (CW >= 12) begin : g_cnt_trunc
      assign cnt12 = cnt_reg[11:0];
    end else begin : g_cnt_ext
      assign cnt12 = {{(12-CW){1'b0}}, cnt_reg};
    end
    if (DATA_SIZE < 32) begin : g_unused_bits
      logic unused_write_bits;
      assign unused_write_bits = &{1'b0, write_data[31:DATA_SIZE]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= write_data[DATA_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      cnt_reg <= cnt_reg + 1'b1;
      else if (pop && !push) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_DISABLED;
      sink_valid <= 1'b0;
      sink_data  <= '0;
    end else if (flush) begin
      sink_valid <= 1'b0;
      sink_data  <= '0;
      state_reg  <= write_data[0] ? ST_FILL : ST_DISABLED;
    end else begin
      case (state_reg)
        ST_DISABLED: begin
          sink_valid <= 1'b0;
          if (enable_reg) state_reg <= ST_FILL;
        end
        ST_FILL: begin
          if (!enable_reg) state_reg <= ST_DISABLED;
          else if (cnt_reg >= CW'(START_LEVEL)) state_reg <= ST_STREAM;
        end
        ST_STREAM: begin
          // Disabling drops whatever sample is sitting in the output register.
          if (!enable_reg) begin
            state_reg  <= ST_DISABLED;
            sink_valid <= 1'b0;
          end else if (pop) begin
            sink_valid <= 1'b1;
            sink_data  <= mem[rd_ptr_reg];
          end else if (sink_ready) begin
            sink_valid <= 1'b0;
            if (underrun) state_reg <= ST_FILL;
          end
        end
        default: begin
          state_reg  <= ST_DISABLED;
          sink_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_reg <= 1'b0;
      irq_en_reg <= 1'b0;
    end else if (bus_wr_ctrl) begin
      enable_reg <= write_data[0];
      irq_en_reg <= write_data[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_reg <= 1'b0;
      udr_sticky_reg <= 1'b0;
      udr_cnt_reg    <= '0;
    end else if (clr) begin
      ovf_sticky_reg <= 1'b0;
      udr_sticky_reg <= 1'b0;
      udr_cnt_reg    <= '0;
    end else begin
      if (bus_wr_data && full) ovf_sticky_reg <= 1'b1;
      if (underrun) begin
        udr_sticky_reg <= 1'b1;
        if (udr_cnt_reg != 16'hFFFF) udr_cnt_reg <= udr_cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq       <= 1'b0;
      read_data <= '0;
    end else begin
      irq <= irq_en_reg && enable_reg && (cnt_reg < CW'(LOW_WATER));
      if (chipselect && read) begin
        if (address)
          read_data <= {26'b0, 2'(state_reg), 1'b0, irq_en_reg, 1'b0, enable_reg};
        else
          read_data <= {udr_cnt_reg, udr_sticky_reg, ovf_sticky_reg, full, empty, cnt12};
      end
    end
  end

endmodule
